// File: rtl/controlador_pkg.sv
// Shared constants for the accumulator controller: opcodes, FSM encodings,
// display refresh default, 7-segment patterns and the decimal split helper.
package controlador_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    localparam int REFRESH_DIV_DEFAULT = 50000;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;

    // Codes 0..9 are decimal digits; these two select the non-numeric glyphs.
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct packed {
        logic       neg;
        logic [3:0] tens;
        logic [3:0] units;
    } disp_t;

    function automatic disp_t to_disp(input logic [5:0] r);
        disp_t      d;
        logic [5:0] mag;
        mag     = r[5] ? (~r + 6'd1) : r;
        d.neg   = r[5];
        d.tens  = 4'(mag / 6'd10);
        d.units = 4'(mag % 6'd10);
        return d;
    endfunction

endpackage

// File: rtl/decod7seg.sv
// Digit code to active-low 7-segment pattern; codes above 9 give minus or blank.
module decod7seg
    import controlador_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_DIGIT[digit_i];
        end else if (digit_i == CODE_MINUS) begin
            seg_o = SEG_MINUS;
        end
    end

endmodule

// File: rtl/somador4bits.sv
// 4-bit adder/subtractor with a 6-bit two's-complement result; te0=1 subtracts b.
module somador4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       te0,
    output logic [5:0] s
);

    logic [5:0] b_ext;

    assign b_ext = {2'b00, b} ^ {6{te0}};
    assign s     = {2'b00, a} + b_ext + {5'b00000, te0};

endmodule

// File: rtl/controlador_somador.sv
// Accumulator controller: LOAD/ADD/SUB/CLEAR through a shared adder, with a
// multiplexed three-digit signed decimal display of the last result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready; accepts a command, registers op and operand
// ST_EXEC  | adder fed with acc and registered operand, sum captured
// ST_WRITE | acc, resultado and flags updated on leaving; done follows
module controlador_somador
    import controlador_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] operando,
    output logic       ready,
    output logic       done,
    output logic [3:0] acc,
    output logic [5:0] resultado,
    output logic       ovf,
    output logic       unf,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [3:0]    opnd_q, opnd_d;
    logic [5:0]    sum_q, sum_d;
    logic [3:0]    acc_q, acc_d;
    logic [5:0]    res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          done_q, done_d;
    logic [5:0]    disp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;

    logic [5:0]    soma;
    logic          te0;
    disp_t         digits;
    logic [3:0]    code;

    assign te0 = (op_q == OP_SUB);

    somador4bits u_somador (
        .a   (acc_q),
        .b   (opnd_q),
        .te0 (te0),
        .s   (soma)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        sum_d   = sum_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    opnd_d  = operando;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sum_d   = soma;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_LOAD: begin
                        res_d = {2'b00, opnd_q};
                        acc_d = opnd_q;
                    end
                    OP_ADD: begin
                        res_d = sum_q;
                        // ADD results span 0..30, so bit 4 alone flags >15
                        if (sum_q[4]) begin
                            acc_d = 4'd15;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_q[3:0];
                        end
                    end
                    OP_SUB: begin
                        res_d = sum_q;
                        if (sum_q[5]) begin
                            acc_d = 4'd0;
                            unf_d = 1'b1;
                        end else begin
                            acc_d = sum_q[3:0];
                        end
                    end
                    OP_CLEAR: begin
                        res_d = 6'd0;
                        acc_d = 4'd0;
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (sel_q)
                DIG_UNITS: sel_d = DIG_TENS;
                DIG_TENS:  sel_d = DIG_SIGN;
                default:   sel_d = DIG_UNITS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            opnd_q  <= 4'd0;
            sum_q   <= 6'd0;
            acc_q   <= 4'd0;
            res_q   <= 6'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= 6'd0;
            cnt_q   <= '0;
            sel_q   <= DIG_UNITS;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
            disp_q  <= res_q;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // The display works from a one-cycle-delayed copy of resultado.
    assign digits = to_disp(disp_q);

    always_comb begin
        code = digits.units;
        an   = 3'b110;
        case (sel_q)
            DIG_TENS: begin
                code = digits.tens;
                an   = 3'b101;
            end
            DIG_SIGN: begin
                code = digits.neg ? CODE_MINUS : CODE_BLANK;
                an   = 3'b011;
            end
            default: begin
                code = digits.units;
                an   = 3'b110;
            end
        endcase
    end

    decod7seg u_decod (
        .digit_i (code),
        .seg_o   (seg)
    );

    assign ready     = (state_q == ST_IDLE);
    assign done      = done_q;
    assign acc       = acc_q;
    assign resultado = res_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_controlador_somador.sv
// Self-checking bench for controlador_somador: command table with a done-time
// scoreboard, display rotation, back-to-back issue and mid-command reset.
module tb_controlador_somador;

    localparam int RDIV = 4;
    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] SUB  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [1:0] op;
        logic [3:0] opnd;
        logic [3:0] acc;
        logic [5:0] res;
        logic       ovf;
        logic       unf;
        int         done_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [3:0] operando;
    logic       ready;
    logic       done;
    logic [3:0] acc;
    logic [5:0] resultado;
    logic       ovf;
    logic       unf;
    logic [6:0] seg;
    logic [2:0] an;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t exp_q[$];
    vec_t tbl[12];
    vec_t bb[7];

    controlador_somador #(.REFRESH_DIV(RDIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operando  (operando),
        .ready     (ready),
        .done      (done),
        .acc       (acc),
        .resultado (resultado),
        .ovf       (ovf),
        .unf       (unf),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding command.
    vec_t e;
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("ready_in_done", 32'(ready), 32'(1));
                chk("acc", 32'(acc), 32'(e.acc));
                chk("resultado", 32'(resultado), 32'(e.res));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("unf", 32'(unf), 32'(e.unf));
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
            e = exp_q.pop_front();
            chk("missing_done", 32'(0), 32'(1));
        end
    end

    task automatic send(input vec_t v);
        int g;
        g = 0;
        while (!ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_send", 32'(ready), 32'(1));
        start    = 1'b1;
        op       = v.op;
        operando = v.opnd;
        v.done_cyc = cyc + 3;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_display(input logic [6:0] su, input logic [6:0] st, input logic [6:0] ss);
        logic [2:0] seen;
        seen = 3'b000;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3 * RDIV; k++) begin
            case (an)
                3'b110: begin seen[0] = 1'b1; chk("seg_units", 32'(seg), 32'(su)); end
                3'b101: begin seen[1] = 1'b1; chk("seg_tens", 32'(seg), 32'(st)); end
                3'b011: begin seen[2] = 1'b1; chk("seg_sign", 32'(seg), 32'(ss)); end
                default: chk("an_one_low", 32'(an), 32'(3'b110));
            endcase
            @(negedge clk);
        end
        chk("digits_seen", 32'(seen), 32'(3'b111));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_an;
        int         acc_cyc[7];
        int         g;

        tbl[0]  = '{LOAD, 4'd5,  4'd5,  6'd5,       1'b0, 1'b0, 0};
        tbl[1]  = '{ADD,  4'd9,  4'd14, 6'd14,      1'b0, 1'b0, 0};
        tbl[2]  = '{ADD,  4'd3,  4'd15, 6'd17,      1'b1, 1'b0, 0};
        tbl[3]  = '{CLR,  4'd0,  4'd0,  6'd0,       1'b0, 1'b0, 0};
        tbl[4]  = '{LOAD, 4'd3,  4'd3,  6'd3,       1'b0, 1'b0, 0};
        tbl[5]  = '{SUB,  4'd7,  4'd0,  6'b111100,  1'b0, 1'b1, 0};
        tbl[6]  = '{ADD,  4'd15, 4'd15, 6'd15,      1'b0, 1'b1, 0};
        tbl[7]  = '{ADD,  4'd15, 4'd15, 6'd30,      1'b1, 1'b1, 0};
        tbl[8]  = '{CLR,  4'd9,  4'd0,  6'd0,       1'b0, 1'b0, 0};
        tbl[9]  = '{LOAD, 4'd7,  4'd7,  6'd7,       1'b0, 1'b0, 0};
        tbl[10] = '{SUB,  4'd7,  4'd0,  6'd0,       1'b0, 1'b0, 0};
        tbl[11] = '{LOAD, 4'd0,  4'd0,  6'd0,       1'b0, 1'b0, 0};

        bb[0] = '{CLR,  4'd0,  4'd0,  6'd0,  1'b0, 1'b0, 0};
        bb[1] = '{LOAD, 4'd2,  4'd2,  6'd2,  1'b0, 1'b0, 0};
        bb[2] = '{ADD,  4'd4,  4'd6,  6'd6,  1'b0, 1'b0, 0};
        bb[3] = '{SUB,  4'd1,  4'd5,  6'd5,  1'b0, 1'b0, 0};
        bb[4] = '{ADD,  4'd7,  4'd12, 6'd12, 1'b0, 1'b0, 0};
        bb[5] = '{SUB,  4'd12, 4'd0,  6'd0,  1'b0, 1'b0, 0};
        bb[6] = '{LOAD, 4'd9,  4'd9,  6'd9,  1'b0, 1'b0, 0};

        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        operando = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_acc", 32'(acc), 32'(0));
        chk("rst_resultado", 32'(resultado), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_unf", 32'(unf), 32'(0));
        chk("rst_an", 32'(an), 32'(3'b110));
        chk("rst_seg", 32'(seg), 32'(S0));

        // Idle display rotation straight out of reset
        rst_n = 1'b1;
        for (int k = 0; k <= 3 * RDIV; k++) begin
            case ((k / RDIV) % 3)
                0:       exp_an = 3'b110;
                1:       exp_an = 3'b101;
                default: exp_an = 3'b011;
            endcase
            chk("idle_an_seq", 32'(an), 32'(exp_an));
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) begin
            send(tbl[i]);
            if (i == 5) begin
                drain();
                check_display(S4, S0, SM);
            end else if (i == 7) begin
                drain();
                check_display(S0, S3, SB);
            end
        end
        drain();

        // start held high; operands scrambled while busy must be ignored
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            g = 0;
            while (!ready && g < 10) begin
                op       = 2'($urandom);
                operando = 4'($urandom);
                @(negedge clk);
                g++;
            end
            chk("bb_ready", 32'(ready), 32'(1));
            op         = bb[i].op;
            operando   = bb[i].opnd;
            acc_cyc[i] = cyc;
            if (i > 0) chk("bb_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(3));
            bb[i].done_cyc = cyc + 3;
            exp_q.push_back(bb[i]);
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset during EXEC of ADD 9 aborts the command
        send('{LOAD, 4'd6, 4'd6, 6'd6, 1'b0, 1'b0, 0});
        drain();
        start    = 1'b1;
        op       = ADD;
        operando = 4'd9;
        @(negedge clk);
        start = 1'b0;
        chk("abort_in_exec", 32'(ready), 32'(0));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_done", 32'(done), 32'(0));
            @(negedge clk);
        end
        chk("abort_acc", 32'(acc), 32'(0));
        chk("abort_resultado", 32'(resultado), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        chk("abort_unf", 32'(unf), 32'(0));
        chk("abort_ready", 32'(ready), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_somador.md
CONTROLADOR_SOMADOR -- requirements
Module: controlador_somador

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each display digit stays enabled.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  command request; accepted when start=1 and ready=1.
REQ-005 op  input  2  command: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-006 operando  input  4  unsigned operand, 0..15.
REQ-007 ready  output  1  high only in state IDLE.
REQ-008 done  output  1  one-cycle pulse when a command completes.
REQ-009 acc  output  4  unsigned accumulator.
REQ-010 resultado  output  6  two's-complement result of the last command.
REQ-011 ovf  output  1  sticky flag: ADD result exceeded 15.
REQ-012 unf  output  1  sticky flag: SUB result fell below 0.
REQ-013 seg  output  7  active-low segments {g,f,e,d,c,b,a} of the currently enabled digit.
REQ-014 an  output  3  active-low digit enables: an[2] sign, an[1] tens, an[0] units.

Function
REQ-015 States SHALL be IDLE, EXEC and WRITE; IDLE->EXEC on accept, EXEC->WRITE unconditionally, WRITE->IDLE unconditionally.
REQ-016 On accept, the block SHALL register op and operando; start during EXEC or WRITE SHALL be ignored.
REQ-017 In EXEC, the adder SHALL receive a=acc, b=registered operando, te0=1 for SUB and 0 otherwise.
REQ-018 At the WRITE edge: LOAD sets resultado={2'b00,operando}; ADD/SUB set resultado=adder s[5:0]; CLEAR sets resultado=0.
REQ-019 At the WRITE edge: LOAD sets acc=operando; ADD sets acc=min(result,15) and ovf=1 if result>15; SUB sets acc=0 and unf=1 if result<0, else acc=result[3:0]; CLEAR sets acc=0, ovf=0, unf=0.
REQ-020 Latency: done SHALL be 1 exactly in the cycle after WRITE, i.e. 3 edges after accept; ready returns to 1 in that same cycle.
REQ-021 A new start presented in the done cycle SHALL be accepted, giving back-to-back throughput of one command per 3 cycles.
REQ-022 Display SHALL show resultado in decimal: sign digit shows '-' (segment g only) when negative, blank otherwise; tens 0..3; units 0..9.
REQ-023 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit select SHALL rotate units->tens->sign->units, with exactly one an bit low.
REQ-024 Display SHALL update in the cycle after resultado changes; refresh timing SHALL be independent of command activity.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, acc=0, resultado=0, ovf=0, unf=0, done=0, refresh counter=0, digit select=units.
REQ-026 Reset mid-command (EXEC or WRITE) SHALL abort the command: no done pulse, and acc/flags take their reset values.
REQ-027 After reset, an=3'b110 and seg=7'b1000000 (units '0').

Structure
REQ-028 Shared package controlador_pkg SHALL hold opcode constants, state encodings, the REFRESH_DIV default and the 7-segment digit/minus/blank patterns.
REQ-029 The adder SHALL be the existing somador4bits instance; the datapath SHALL contain no other adder or subtractor.
REQ-030 One new sub-module decod7seg (4-bit digit in, 7-bit active-low segments out, blank code supported) SHALL be used.

Verification (REFRESH_DIV=4 in the bench)
REQ-031 Reset, then LOAD 5 -> done 3 edges after accept; acc=5, resultado=6'd5, ovf=0, unf=0.
REQ-032 acc=5, ADD 9 -> resultado=14, acc=14; then ADD 3 -> resultado=17, acc=15, ovf=1; then CLEAR -> acc=0, ovf=0.
REQ-033 LOAD 3, then SUB 7 -> resultado=6'b111100 (-4), acc=0, unf=1; display shows sign '-', tens 0, units 4.
REQ-034 start held high continuously with alternating ops -> accepts exactly every 3 cycles; no command lost or duplicated.
REQ-035 Assert rst_n=0 during EXEC of ADD 9 -> no done; acc=0; resultado=0 on release.
REQ-036 Idle display -> an sequence 110, 101, 011, 110, with each value held for 4 cycles.
